model_clock_ctrl: RTL and testbench
===================================

Name: model_clock_ctrl

Overview:
- Controls when the model advances. It replaces the fixed 100 MHz-to-1 Hz clock division with a one-cycle tick enable on the fast clock.
- Four modes: free-run at a programmable power-of-two period, pause, single-step, and burst of N steps.
- Commands arrive as bytes on a valid/ready stream, normally driven by the UART receiver on usb_rx.
- The FPGA top gates the model's clock enable (or derives its model clock) from tick.

Parameters:
- DEFAULT_DIV_EXP, 26: tick period exponent after reset (period = 2**exp clk cycles); 26 gives about 1 Hz at 100 MHz.
- AUTO_RUN, 1: 1 = RUN after reset, 0 = PAUSE after reset.
- CNT_W, 32: width of the period counter; must be greater than 31.

Ports:
- clk  in  1  main clock (100 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- cmd_data  in  8  command or argument byte.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  block accepts a byte; transfer occurs when cmd_valid && cmd_ready on a rising edge of clk.
- tick  out  1  one-clk-cycle model advance pulse.
- running  out  1  high in RUN or BURST.
- div_exp  out  5  current period exponent.
- tick_count  out  16  number of ticks issued since reset; wraps 0xFFFF->0x0000.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a clk edge, at any time, including while waiting for an argument):
  - state = RUN if AUTO_RUN else PAUSE; any pending argument is discarded.
  - tick = 0, tick_count = 0, period counter = 0, div_exp = DEFAULT_DIV_EXP[4:0].
  - cmd_ready = 0 during reset; cmd_ready = 1 from the first cycle after rst_n is high, and stays 1 (the block never back-pressures).
  - running = AUTO_RUN.
- States: PAUSE, RUN, BURST, plus an argument flag ARG_B or ARG_D that coexists with the current mode.
- Command bytes (only processed when no argument is pending):
  - 0x52 'R': enter RUN, counter = 0.
  - 0x50 'P': enter PAUSE, counter = 0. Any tick that would have been issued in the cycle after acceptance is suppressed.
  - 0x53 'S': only in PAUSE. tick = 1 exactly in the cycle after acceptance. Ignored in RUN and BURST.
  - 0x42 'B': set ARG_B. The next accepted byte N (any value, including command codes) is the burst length.
    - N = 0: enter PAUSE, no tick.
    - N > 0: enter BURST with remaining = N, counter = 0.
  - 0x44 'D': set ARG_D. The next accepted byte sets div_exp = byte[4:0] (upper bits ignored) and counter = 0. The mode is unchanged.
  - Any other byte: ignored, no state change.
- Mode continues while an argument is pending; RUN keeps ticking.
- Period in RUN and BURST:
  - The counter increments every cycle.
  - When counter == 2**div_exp - 1: counter goes to 0 and tick = 1 on the next cycle.
  - First tick is 2**div_exp cycles after the cycle that entered the mode or reset the counter, then one every 2**div_exp cycles.
  - div_exp = 0 gives a tick every cycle.
- BURST:
  - Each tick decrements remaining.
  - When the tick with remaining == 1 is issued, state = PAUSE and running falls in the same cycle the final tick is high.
  - 'R' or 'P' during BURST abort it immediately.
  - 'B' during BURST restarts it with the new N.
- PAUSE: counter held at 0, no ticks except those from 'S'.
- tick_count increments in every cycle where tick = 1.
- running = 1 in RUN or BURST, 0 in PAUSE. It updates in the cycle after the command is accepted.

Test Plan:
- Reset with AUTO_RUN=1, DEFAULT_DIV_EXP=3; release rst_n -> tick high one cycle every 8 cycles, first tick 8 cycles after reset release; tick_count 1, 2, 3...; cmd_ready = 1.
- In RUN, send 'D' then 0x21 -> div_exp = 1, counter restarts, ticks every 2 cycles.
- Send 'P', then 'S' three times, each 5 cycles apart -> exactly 3 single-cycle ticks, each one cycle after its 'S'; running = 0 throughout.
- PAUSE, div_exp = 2, send 'B' then 0x03 -> running = 1, 3 ticks spaced 4 cycles apart, then running = 0 and no further ticks; 'B' then 0x00 -> no ticks.
- BURST of 10 with 'P' sent after the 2nd tick -> no further ticks, tick_count advanced by exactly 2; unknown byte 0x7A in PAUSE -> no change.
- Send 'D', then assert rst_n low for 1 cycle before the argument, then send 0x52 -> treated as the 'R' command, div_exp = DEFAULT_DIV_EXP.

Source files
------------

// File: rtl/model_clock_ctrl.sv
//-----------------------------------------------------------------------------
// model_clock_ctrl
//
// Decides when the model advances. Instead of dividing the fast clock down to
// a slow model clock, this block emits a one-cycle `tick` enable on the fast
// clock. Four operating modes are driven by a byte command stream:
//   'R' (0x52)      free-run, one tick every 2**div_exp cycles
//   'P' (0x50)      pause, no ticks
//   'S' (0x53)      single step (only honoured while paused)
//   'B' (0x42) N    burst of N ticks at the current period, then pause
//   'D' (0x44) E    set period exponent div_exp = E[4:0], mode unchanged
// Any other command byte is ignored. 'B' and 'D' take one argument byte; the
// argument is taken verbatim even if it equals a command code.
//
// Ports
//   clk         in   main clock (100 MHz)
//   rst_n       in   synchronous active-low reset
//   cmd_data    in   command or argument byte
//   cmd_valid   in   cmd_data is valid
//   cmd_ready   out  block accepts a byte (always 1 outside reset)
//   tick        out  one-clk-cycle model advance pulse
//   running     out  1 in RUN or BURST, 0 in PAUSE
//   div_exp     out  current period exponent
//   tick_count  out  ticks issued since reset, wraps at 16 bits
//
// Handshake: a byte transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The source holds cmd_data stable while cmd_valid
// is high and not yet accepted; this block never withdraws cmd_ready once
// out of reset, so every valid byte is accepted on the edge it is presented.
//
// All outputs come straight from flops.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module model_clock_ctrl #(
    parameter int unsigned DEFAULT_DIV_EXP = 26,
    parameter int unsigned AUTO_RUN        = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        tick,
    output logic        running,
    output logic [4:0]  div_exp,
    output logic [15:0] tick_count
);

    // The counter must hold 2**31 - 1 for the largest exponent.
    if (CNT_W < 32) begin : g_cnt_w_check
        $error("model_clock_ctrl: CNT_W must be at least 32");
    end

    //-------------------------------------------------------------------------
    // Command codes
    //-------------------------------------------------------------------------
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_BURST = 8'h42;
    localparam logic [7:0] CMD_DIV   = 8'h44;

    //-------------------------------------------------------------------------
    // Control state: the mode plus an independent "argument pending" flag.
    // Kept together in one struct so the whole control state is visible as a
    // single signal (ctrl_q) when probing the design.
    //-------------------------------------------------------------------------
    typedef enum logic [1:0] {
        MODE_PAUSE = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BURST = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ARG_NONE = 2'd0,
        ARG_B    = 2'd1,
        ARG_D    = 2'd2
    } arg_e;

    typedef struct packed {
        mode_e mode;
        arg_e  arg;
    } ctrl_state_t;

    localparam mode_e          RESET_MODE    = (AUTO_RUN != 0) ? MODE_RUN : MODE_PAUSE;
    localparam logic           RESET_RUNNING = (AUTO_RUN != 0);
    localparam logic [4:0]     RESET_DIV_EXP = 5'(DEFAULT_DIV_EXP);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    //-------------------------------------------------------------------------
    // Registers and next-state signals
    //-------------------------------------------------------------------------
    ctrl_state_t      ctrl_q,      ctrl_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [4:0]       div_exp_q,   div_exp_d;
    logic             tick_q,      tick_d;
    logic             running_q,   running_d;
    logic [15:0]      tick_count_q;
    logic             cmd_ready_q;

    logic             cmd_accept;
    logic             cnt_restart;
    logic             step_req;
    logic [CNT_W-1:0] period_mask;
    logic             period_end;

    assign cmd_accept  = cmd_valid && cmd_ready_q;

    // Terminal count is 2**div_exp - 1; with div_exp = 0 it is 0, so every
    // cycle is a period end and the block ticks continuously.
    assign period_mask = (CNT_ONE << div_exp_q) - CNT_ONE;
    assign period_end  = (cnt_q == period_mask);

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        div_exp_d   = div_exp_q;
        tick_d      = 1'b0;
        cnt_restart = 1'b0;
        step_req    = 1'b0;

        // Command / argument decode.
        if (cmd_accept) begin
            case (ctrl_q.arg)
                ARG_B: begin
                    ctrl_d.arg  = ARG_NONE;
                    cnt_restart = 1'b1;
                    if (cmd_data == 8'd0) begin
                        ctrl_d.mode = MODE_PAUSE;
                    end else begin
                        ctrl_d.mode = MODE_BURST;
                        remaining_d = cmd_data;
                    end
                end
                ARG_D: begin
                    ctrl_d.arg  = ARG_NONE;
                    div_exp_d   = cmd_data[4:0];
                    cnt_restart = 1'b1;
                end
                default: begin
                    case (cmd_data)
                        CMD_RUN: begin
                            ctrl_d.mode = MODE_RUN;
                            cnt_restart = 1'b1;
                        end
                        CMD_PAUSE: begin
                            ctrl_d.mode = MODE_PAUSE;
                            cnt_restart = 1'b1;
                        end
                        CMD_STEP: begin
                            step_req = (ctrl_q.mode == MODE_PAUSE);
                        end
                        CMD_BURST: begin
                            ctrl_d.arg = ARG_B;
                        end
                        CMD_DIV: begin
                            ctrl_d.arg = ARG_D;
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end

        // Period counter. A command that restarts the counter also cancels
        // any tick that would have come out of the current cycle, so a new
        // mode or period always starts from a clean phase.
        if (cnt_restart) begin
            cnt_d = '0;
        end else if (ctrl_q.mode == MODE_PAUSE) begin
            cnt_d  = '0;
            tick_d = step_req;
        end else if (period_end) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (ctrl_q.mode == MODE_BURST) begin
                remaining_d = remaining_q - 8'd1;
                // Final burst tick: drop to PAUSE on the same edge that
                // raises the tick, so running falls while tick is high.
                if (remaining_q == 8'd1) begin
                    ctrl_d.mode = MODE_PAUSE;
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        running_d = (ctrl_d.mode != MODE_PAUSE);
    end

    //-------------------------------------------------------------------------
    // State registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q.mode  <= RESET_MODE;
            ctrl_q.arg   <= ARG_NONE;
            cnt_q        <= '0;
            remaining_q  <= 8'd0;
            div_exp_q    <= RESET_DIV_EXP;
            tick_q       <= 1'b0;
            running_q    <= RESET_RUNNING;
            tick_count_q <= 16'd0;
            cmd_ready_q  <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            div_exp_q    <= div_exp_d;
            tick_q       <= tick_d;
            running_q    <= running_d;
            tick_count_q <= tick_count_q + {15'd0, tick_q};
            cmd_ready_q  <= 1'b1;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign cmd_ready  = cmd_ready_q;
    assign tick       = tick_q;
    assign running    = running_q;
    assign div_exp    = div_exp_q;
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_model_clock_ctrl.sv
`timescale 1ns/1ps

module tb_model_clock_ctrl;

    localparam int unsigned DIV0 = 3;

    //-------------------------------------------------------------------------
    // Clock / reset
    //-------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        tick;
    logic        running;
    logic [4:0]  div_exp;
    logic [15:0] tick_count;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;   // number of rising edges so far
    int tick_seen = 0;   // ticks observed since the last reset

    // Scoreboard: cycle numbers in which a tick is expected.
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    model_clock_ctrl #(
        .DEFAULT_DIV_EXP (DIV0),
        .AUTO_RUN        (1),
        .CNT_W           (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .tick       (tick),
        .running    (running),
        .div_exp    (div_exp),
        .tick_count (tick_count)
    );

    //-------------------------------------------------------------------------
    // Checking helpers
    //-------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle c.
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a falling edge; the byte is accepted on the next rising
    // edge and the task returns at the falling edge right after it, so on
    // return cyc equals the acceptance edge. For a step command the
    // expected tick (cycle right after acceptance) is queued up front.
    task automatic send(input logic [7:0] b, input bit is_step);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        if (is_step) exp_q.push_back(32'(cyc + 1));
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom_range(0, 255));
    endtask

    //-------------------------------------------------------------------------
    // Monitor: every tick must match the head of the expected queue, and
    // tick_count must equal the ticks seen in earlier cycles.
    //-------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n !== 1'b1) begin
            tick_seen = 0;
        end else begin
            check("tick_count_track", 32'(tick_count), 32'(tick_seen[15:0]));
            if (tick === 1'b1) begin
                tick_seen++;
                test_cnt++;
                assert (exp_q.size() != 0) else begin
                    fail_cnt++;
                    $error("FAIL tick_unexpected: tick seen at cycle %0d, none expected", cyc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tick_cycle", 32'(cyc), e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    //-------------------------------------------------------------------------
    // Directed stimulus
    //-------------------------------------------------------------------------
    initial begin
        int t_r, t_a, t_p, t_b, t_c, t_s;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        t_r = cyc;
        check("rst_tick",       32'(tick),       32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        check("rst_running",    32'(running),    32'd1);
        check("rst_div_exp",    32'(div_exp),    32'(DIV0));
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        for (int k = 1; k <= 5; k++) exp_q.push_back(32'(t_r + 8 * k));
        #1 rst_n = 1'b1;

        // Free run at 2**3 after reset.
        wait_until(t_r + 1);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        check("run_running",     32'(running),   32'd1);
        wait_until(t_r + 34);
        check("run_tick_count",  32'(tick_count), 32'd4);
        check("run_pending",     32'(exp_q.size()), 32'd1);

        // 'D' pending while RUN keeps ticking (tick at t_r+40), then 0x21.
        send(8'h44, 1'b0);
        check("d_pending_div", 32'(div_exp), 32'(DIV0));
        wait_until(t_r + 42);
        send(8'h21, 1'b0);
        t_a = cyc;
        check("d_div_exp", 32'(div_exp), 32'd1);
        check("d_running", 32'(running), 32'd1);
        for (int k = 1; k <= 5; k++) exp_q.push_back(32'(t_a + 2 * k));
        wait_until(t_a + 11);
        check("d_tick_count", 32'(tick_count), 32'd10);

        // Pause; the tick due right after acceptance is suppressed.
        send(8'h50, 1'b0);
        t_p = cyc;
        check("p_running", 32'(running), 32'd0);

        // Three single steps, 5 cycles apart.
        for (int k = 1; k <= 3; k++) begin
            wait_until(t_p + 5 * k - 1);
            send(8'h53, 1'b1);
            check("s_running", 32'(running), 32'd0);
        end
        wait_until(t_p + 20);
        check("s_tick_count", 32'(tick_count), 32'd13);
        check("s_queue_empty", 32'(exp_q.size()), 32'd0);

        // div_exp = 2, burst of 3.
        send(8'h44, 1'b0);
        send(8'h02, 1'b0);
        check("b_div_exp", 32'(div_exp), 32'd2);
        check("b_running_pre", 32'(running), 32'd0);
        send(8'h42, 1'b0);
        send(8'h03, 1'b0);
        t_b = cyc;
        check("b_running", 32'(running), 32'd1);
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(t_b + 4 * k));
        wait_until(t_b + 11);
        check("b_running_last", 32'(running), 32'd1);
        wait_until(t_b + 12);
        check("b_running_fall", 32'(running), 32'd0);
        wait_until(t_b + 20);
        check("b_tick_count", 32'(tick_count), 32'd16);
        check("b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Burst of zero: stays paused, no ticks.
        send(8'h42, 1'b0);
        send(8'h00, 1'b0);
        check("b0_running", 32'(running), 32'd0);
        wait_until(t_b + 32);
        check("b0_tick_count", 32'(tick_count), 32'd16);

        // Burst of 10 aborted by 'P' after the 2nd tick.
        send(8'h42, 1'b0);
        send(8'h0A, 1'b0);
        t_c = cyc;
        exp_q.push_back(32'(t_c + 4));
        exp_q.push_back(32'(t_c + 8));
        wait_until(t_c + 9);
        check("ab_running", 32'(running), 32'd1);
        send(8'h50, 1'b0);
        check("ab_running_off", 32'(running), 32'd0);
        wait_until(t_c + 30);
        check("ab_tick_count", 32'(tick_count), 32'd18);
        check("ab_queue_empty", 32'(exp_q.size()), 32'd0);

        // Unknown byte in PAUSE: no change.
        send(8'h7A, 1'b0);
        wait_until(t_c + 40);
        check("unk_div_exp",    32'(div_exp),    32'd2);
        check("unk_running",    32'(running),    32'd0);
        check("unk_tick_count", 32'(tick_count), 32'd18);

        // 'D', then reset before its argument; 0x52 must act as 'R'.
        send(8'h44, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst2_cmd_ready",  32'(cmd_ready),  32'd0);
        check("rst2_div_exp",    32'(div_exp),    32'(DIV0));
        check("rst2_tick_count", 32'(tick_count), 32'd0);
        check("rst2_running",    32'(running),    32'd1);
        #1 rst_n = 1'b1;
        wait_until(t_c + 43);
        send(8'h52, 1'b0);
        t_s = cyc;
        check("r_div_exp", 32'(div_exp), 32'(DIV0));
        check("r_running", 32'(running), 32'd1);
        exp_q.push_back(32'(t_s + 8));
        exp_q.push_back(32'(t_s + 16));
        wait_until(t_s + 17);
        check("r_tick_count",  32'(tick_count),   32'd2);
        check("r_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
